fmac_fifo_rd_framer: RTL and testbench
======================================

Name: fmac_fifo_rd_framer

Overview:
- Read-side consumer of the MAC 4Kx8 byte FIFO.
- Drains length-prefixed frames stored in the FIFO: a 2-byte big-endian length header, then the payload bytes.
- Re-emits each payload as a byte stream with sop/eop and valid/ready backpressure.
- Sits between the FIFO read port (rdreq/q/rdempty/rdusedw) and the downstream MAC TX/host logic, in the FIFO read clock domain.

Parameters:
- WIDTH, 8, FIFO/stream data width in bits; only 8 is supported.
- PTR, 12, FIFO pointer width; rdusedw is PTR+1 bits.
- MAX_LEN, 1518, largest legal payload length in bytes; larger headers cause the frame to be dropped.

Ports:
- clk  in  1  FIFO read clock (drives the FIFO rdclk).
- reset  in  1  synchronous, active-high reset.
- rdreq  out  1  FIFO read request.
- q  in  WIDTH  FIFO read data, valid exactly 1 cycle after rdreq.
- rdempty  in  1  FIFO empty.
- rdusedw  in  PTR+1  FIFO fill level.
- out_data  out  WIDTH  payload byte.
- out_valid  out  1  out_data/sop/eop valid.
- out_sop  out  1  first payload byte of a frame.
- out_eop  out  1  last payload byte of a frame.
- out_ready  in  1  downstream accepts a byte when out_valid and out_ready are both high.
- busy  out  1  state is not IDLE.
- drop_pulse  out  1  one-cycle pulse when a frame is discarded.
- frame_cnt  out  16  frames delivered; wraps modulo 2^16.
- drop_cnt  out  16  frames dropped; wraps modulo 2^16.

Behaviour:
- Reset (synchronous, active-high):
  - All outputs 0, state IDLE.
  - Output buffer and in-flight tracking cleared.
  - Reset takes effect in the same cycle as any in-progress read; a partially read frame is abandoned and its remaining FIFO bytes are not resynchronised.
- Read latency: q is captured 1 cycle after rdreq=1. A registered in-flight flag tags each returned byte with the state that issued it.
- Output buffer: 2-entry skid buffer.
  - rdreq=1 only when !rdempty, the state requires a byte, and (buffer occupancy + in-flight) < 2.
  - Header and drop bytes bypass the buffer, so the buffer limit does not apply to them.
- Stream rules:
  - out_valid never drops while out_valid=1 and out_ready=0.
  - out_data, out_sop and out_eop are held stable until the byte is accepted.
- States:
  - IDLE: wait for rdusedw >= 2, then go to HDR_HI.
  - HDR_HI: read 1 byte into len[15:8], go to HDR_LO.
  - HDR_LO: read 1 byte into len[7:0], then go to CHECK.
  - CHECK (1 cycle):
    - len == 0: drop_pulse, drop_cnt+1, go to IDLE.
    - len > MAX_LEN: go to DROP with remaining count = len.
    - otherwise: go to PAYLOAD with remaining count = len.
  - PAYLOAD: one rdreq per byte until remaining reaches 0.
    - The first returned byte is tagged sop; the byte issued when remaining==1 is tagged eop.
    - Once all bytes are issued, go to DRAIN.
  - DRAIN: wait until the buffer is empty and no read is in flight, then frame_cnt+1 and go to IDLE.
  - DROP: issue rdreq whenever !rdempty and discard q. When remaining reaches 0: drop_pulse, drop_cnt+1, go to IDLE.
- FIFO underrun mid-frame (rdempty=1): rdreq is held low and out_valid may go low between bytes; the frame continues when data arrives.
- len == 1: a single byte is emitted with both out_sop=1 and out_eop=1.
- Counters and arithmetic:
  - The remaining counter is 16 bits.
  - The occupancy comparison is unsigned and at PTR+1 bits.
  - frame_cnt and drop_cnt wrap from 0xFFFF to 0x0000.

Optional Feature:
- Macro FMAC_RD_STORE_FWD_EN.
- Defined: in CHECK, a legal frame waits in a WAIT_FULL state until rdusedw >= len before entering PAYLOAD. The stream then never stalls for FIFO underrun inside a frame.
- Not defined: cut-through; PAYLOAD is entered immediately after CHECK and may stall on rdempty.

Decomposition:
- Shared package fmac_rd_pkg holds:
  - the state enum (IDLE, HDR_HI, HDR_LO, CHECK, WAIT_FULL, PAYLOAD, DRAIN, DROP);
  - the header byte count constant HDR_BYTES=2;
  - the default MAX_LEN.
- One sub-module: fmac_skid_buf2, a 2-entry valid/ready buffer carrying {sop, eop, data}.

Test Plan:
- FIFO holds 00 04 A1 A2 A3 A4, out_ready=1 -> output A1(sop) A2 A3 A4(eop); frame_cnt=1; rdreq deasserted afterwards.
- Same frame with out_ready toggling 1,0,0,1 -> no byte lost or duplicated; out_data held stable while out_valid=1 and out_ready=0.
- Header 07 D0 (2000 > 1518) followed by 2000 bytes, then frame 00 01 5A -> 2000 bytes drained, drop_pulse=1 once, drop_cnt=1; then 5A with sop=eop=1 and frame_cnt=1.
- Header 00 00 -> no output, drop_cnt=1, state returns to IDLE within 4 cycles of the second header byte.
- Cut-through with only 3 of 8 payload bytes present -> 3 bytes output, then stall; the remaining 5 follow when written. With FMAC_RD_STORE_FWD_EN -> no output until rdusedw >= 8.
- reset=1 asserted mid-PAYLOAD -> next cycle all outputs 0 and state IDLE; counters cleared.

Source files
------------

// File: rtl/fmac_rd_pkg.sv
// Shared constants for the MAC FIFO read-side framer: FSM state encodings,
// in-flight read tags, header size and default maximum payload length.
package fmac_rd_pkg;

  localparam int HDR_BYTES       = 2;
  localparam int MAX_LEN_DEFAULT = 1518;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_HDR_HI    = 3'd1;
  localparam state_t ST_HDR_LO    = 3'd2;
  localparam state_t ST_CHECK     = 3'd3;
  localparam state_t ST_WAIT_FULL = 3'd4;
  localparam state_t ST_PAYLOAD   = 3'd5;
  localparam state_t ST_DRAIN     = 3'd6;
  localparam state_t ST_DROP      = 3'd7;

  // Identifies which state issued the read whose byte is returning on q.
  typedef logic [1:0] tag_t;

  localparam tag_t TAG_HI   = 2'd0;
  localparam tag_t TAG_LO   = 2'd1;
  localparam tag_t TAG_PAY  = 2'd2;
  localparam tag_t TAG_DROP = 2'd3;

endpackage

// File: rtl/fmac_skid_buf2.sv
// Two-entry valid/ready buffer carrying {sop, eop, data}; the head entry is
// held stable until accepted. Writers must not push when count is 2.
module fmac_skid_buf2
  import fmac_rd_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic          in_sop,
  input  logic          in_eop,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic          out_sop,
  output logic          out_eop,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic [1:0]    count
);

  logic [DW+1:0] ent0_q, ent0_d;
  logic [DW+1:0] ent1_q, ent1_d;
  logic [DW+1:0] in_ent;
  logic [1:0]    cnt_q, cnt_d;
  logic          pop;

  assign in_ent = {in_sop, in_eop, in_data};
  assign pop    = (cnt_q != 2'd0) && out_ready;

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    if (pop) begin
      ent0_d = ent1_q;
      cnt_d  = cnt_q - 2'd1;
    end
    // A push lands behind whatever survives this cycle's pop.
    if (in_valid && (cnt_d != 2'd2)) begin
      if (cnt_d == 2'd0) begin
        ent0_d = in_ent;
      end else begin
        ent1_d = in_ent;
      end
      cnt_d = cnt_d + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_valid = (cnt_q != 2'd0);
  assign {out_sop, out_eop, out_data} = ent0_q;
  assign count     = cnt_q;

endmodule

// File: rtl/fmac_fifo_rd_framer.sv
// Drains length-prefixed frames (2-byte big-endian header) from the MAC byte FIFO
// and re-emits payloads as a sop/eop valid/ready stream. FMAC_RD_STORE_FWD_EN
// selects store-and-forward (wait for whole payload) instead of cut-through.
module fmac_fifo_rd_framer
  import fmac_rd_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int PTR     = 12,
  parameter int MAX_LEN = MAX_LEN_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  output logic             rdreq,
  input  logic [WIDTH-1:0] q,
  input  logic             rdempty,
  input  logic [PTR:0]     rdusedw,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_sop,
  output logic             out_eop,
  input  logic             out_ready,
  output logic             busy,
  output logic             drop_pulse,
  output logic [15:0]      frame_cnt,
  output logic [15:0]      drop_cnt
);

  state_t           state_q, state_d;
  logic             inflight_q, inflight_d;
  tag_t             tag_q, tag_d;
  logic             tag_sop_q, tag_sop_d;
  logic             tag_eop_q, tag_eop_d;
  logic [WIDTH-1:0] len_hi_q, len_hi_d;
  logic [15:0]      rem_q, rem_d;
  logic             first_q, first_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;
  logic             drop_pulse_q, drop_pulse_d;

  logic             rd_issue;
  logic             buf_in_valid;
  logic [1:0]       buf_cnt;
  logic             buf_valid;
  logic             buf_sop;
  logic             buf_eop;
  logic [WIDTH-1:0] buf_data;
  logic [PTR:0]     occ;
  logic             room;
  logic [15:0]      hdr_len;

  // Bytes already committed to the buffer path: stored plus the one on its way.
  assign occ     = (PTR+1)'(buf_cnt) + (PTR+1)'(inflight_q);
  assign room    = (occ < (PTR+1)'(2));
  // In CHECK the low header byte is the one returning on q this cycle.
  assign hdr_len = {len_hi_q, q};

  always_comb begin
    state_d      = state_q;
    tag_d        = tag_q;
    tag_sop_d    = tag_sop_q;
    tag_eop_d    = tag_eop_q;
    len_hi_d     = len_hi_q;
    rem_d        = rem_q;
    first_d      = first_q;
    frame_cnt_d  = frame_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    drop_pulse_d = 1'b0;
    rd_issue     = 1'b0;
    buf_in_valid = 1'b0;

    if (inflight_q) begin
      case (tag_q)
        TAG_HI:  len_hi_d     = q;
        TAG_PAY: buf_in_valid = 1'b1;
        default: ;
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        if (rdusedw >= (PTR+1)'(HDR_BYTES)) begin
          state_d = ST_HDR_HI;
        end
      end
      ST_HDR_HI: begin
        if (!rdempty) begin
          rd_issue = 1'b1;
          tag_d    = TAG_HI;
          state_d  = ST_HDR_LO;
        end
      end
      ST_HDR_LO: begin
        if (!rdempty) begin
          rd_issue = 1'b1;
          tag_d    = TAG_LO;
          state_d  = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (hdr_len == 16'd0) begin
          drop_pulse_d = 1'b1;
          drop_cnt_d   = drop_cnt_q + 16'd1;
          state_d      = ST_IDLE;
        end else if (hdr_len > 16'(MAX_LEN)) begin
          rem_d   = hdr_len;
          state_d = ST_DROP;
        end else begin
          rem_d   = hdr_len;
          first_d = 1'b1;
`ifdef FMAC_RD_STORE_FWD_EN
          state_d = ST_WAIT_FULL;
`else
          state_d = ST_PAYLOAD;
`endif
        end
      end
      ST_WAIT_FULL: begin
        if (32'(rdusedw) >= 32'(rem_q)) begin
          state_d = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (!rdempty && room) begin
          rd_issue  = 1'b1;
          tag_d     = TAG_PAY;
          tag_sop_d = first_q;
          tag_eop_d = (rem_q == 16'd1);
          first_d   = 1'b0;
          rem_d     = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if ((buf_cnt == 2'd0) && !inflight_q) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = ST_IDLE;
        end
      end
      ST_DROP: begin
        // Discarded bytes never enter the buffer, so no occupancy limit here.
        if (!rdempty) begin
          rd_issue = 1'b1;
          tag_d    = TAG_DROP;
          rem_d    = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
            drop_pulse_d = 1'b1;
            drop_cnt_d   = drop_cnt_q + 16'd1;
            state_d      = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    inflight_d = rd_issue;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      inflight_q   <= 1'b0;
      tag_q        <= TAG_HI;
      tag_sop_q    <= 1'b0;
      tag_eop_q    <= 1'b0;
      rem_q        <= 16'd0;
      first_q      <= 1'b0;
      frame_cnt_q  <= 16'd0;
      drop_cnt_q   <= 16'd0;
      drop_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      inflight_q   <= inflight_d;
      tag_q        <= tag_d;
      tag_sop_q    <= tag_sop_d;
      tag_eop_q    <= tag_eop_d;
      rem_q        <= rem_d;
      first_q      <= first_d;
      frame_cnt_q  <= frame_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      drop_pulse_q <= drop_pulse_d;
    end
  end

  always_ff @(posedge clk) begin
    len_hi_q <= len_hi_d;
  end

  fmac_skid_buf2 #(
    .DW (WIDTH)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (buf_in_valid),
    .in_sop    (tag_sop_q),
    .in_eop    (tag_eop_q),
    .in_data   (q),
    .out_valid (buf_valid),
    .out_sop   (buf_sop),
    .out_eop   (buf_eop),
    .out_data  (buf_data),
    .out_ready (out_ready),
    .count     (buf_cnt)
  );

  assign rdreq      = rd_issue;
  assign out_valid  = buf_valid;
  assign out_sop    = buf_valid & buf_sop;
  assign out_eop    = buf_valid & buf_eop;
  assign out_data   = buf_data;
  assign busy       = (state_q != ST_IDLE);
  assign drop_pulse = drop_pulse_q;
  assign frame_cnt  = frame_cnt_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_fmac_fifo_rd_framer.sv
// Directed bench for fmac_fifo_rd_framer with a behavioural byte FIFO
// (one-cycle read latency) and a stream monitor on the output side.
module tb_fmac_fifo_rd_framer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rdreq;
  logic [7:0]  q = 8'h00;
  logic        rdempty;
  logic [12:0] rdusedw;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_sop;
  logic        out_eop;
  logic        out_ready = 1'b1;
  logic        busy;
  logic        drop_pulse;
  logic [15:0] frame_cnt;
  logic [15:0] drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int pulses  = 0;

  always #5 clk = ~clk;

  fmac_fifo_rd_framer dut (
    .clk        (clk),
    .reset      (reset),
    .rdreq      (rdreq),
    .q          (q),
    .rdempty    (rdempty),
    .rdusedw    (rdusedw),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_sop    (out_sop),
    .out_eop    (out_eop),
    .out_ready  (out_ready),
    .busy       (busy),
    .drop_pulse (drop_pulse),
    .frame_cnt  (frame_cnt),
    .drop_cnt   (drop_cnt)
  );

  // Byte FIFO model: written from the stimulus, read with one-cycle latency.
  logic [7:0] mem [0:8191];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic       flush  = 1'b0;

  assign rdempty = (wr_ptr == rd_ptr);
  assign rdusedw = 13'(wr_ptr - rd_ptr);

  always @(posedge clk) begin
    if (flush) begin
      rd_ptr <= wr_ptr;
    end else if (rdreq && (wr_ptr != rd_ptr)) begin
      q      <= mem[rd_ptr % 8192];
      rd_ptr <= rd_ptr + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: captures accepted bytes and checks hold-while-stalled.
  logic [9:0] cap[$];
  logic [9:0] expq[$];
  logic       pv = 1'b0, pr = 1'b0, prst = 1'b1;
  logic [9:0] pent = '0;

  always @(negedge clk) begin
    if (pv && !pr && !prst) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", {out_sop, out_eop, out_data}, pent);
    end
    if (out_valid && out_ready && !reset) cap.push_back({out_sop, out_eop, out_data});
    if (drop_pulse) pulses++;
    pv   = out_valid;
    pr   = out_ready;
    pent = {out_sop, out_eop, out_data};
    prst = reset;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr % 8192] = b;
    wr_ptr++;
  endtask

  task automatic push_frame(input int n, input logic [7:0] base);
    push(8'(n >> 8));
    push(8'(n));
    for (int i = 0; i < n; i++) push(base + 8'(i));
  endtask

  task automatic add_exp(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) expq.push_back({(i == 0), (i == n - 1), base + 8'(i)});
  endtask

  task automatic clear_caps();
    cap.delete();
    expq.delete();
    pulses = 0;
  endtask

  task automatic check_cap(input string tag);
    int n;
    chk({tag, "_count"}, cap.size(), expq.size());
    n = (cap.size() < expq.size()) ? cap.size() : expq.size();
    for (int i = 0; i < n; i++) chk({tag, "_byte"}, cap[i], expq[i]);
  endtask

  // Waits for the framer to go idle with FIFO and stream empty; toggle drives ready 1,0,0,1.
  task automatic wait_done(input int budget, input bit toggle);
    int c;
    bit done;
    c = 0;
    done = 1'b0;
    while (!done && c < budget) begin
      @(posedge clk);
      #1;
      c++;
      if (toggle) out_ready = ((c % 4) == 0) || ((c % 4) == 3);
      if (c > 3 && !busy && rdempty && !out_valid) done = 1'b1;
    end
    chk("wait_done", done, 1);
    out_ready = 1'b1;
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    tick(3);
    chk("rst_rdreq", rdreq, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_sop", out_sop, 0);
    chk("rst_eop", out_eop, 0);
    chk("rst_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop_pulse", drop_pulse, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    reset = 1'b0;
    tick(2);
    chk("idle_busy", busy, 0);

    // Basic 4-byte frame, ready held high
    clear_caps();
    push_frame(4, 8'hA1);
    add_exp(4, 8'hA1);
    wait_done(200, 1'b0);
    check_cap("basic");
    chk("basic_frame_cnt", frame_cnt, 1);
    chk("basic_drop_cnt", drop_cnt, 0);
    chk("basic_rdreq_low", rdreq, 0);

    // Same frame under backpressure
    clear_caps();
    push_frame(4, 8'hA1);
    add_exp(4, 8'hA1);
    wait_done(200, 1'b1);
    check_cap("bp");
    chk("bp_frame_cnt", frame_cnt, 2);

    // Oversize header: 2000 bytes discarded, then a 1-byte frame
    clear_caps();
    push(8'h07);
    push(8'hD0);
    for (int i = 0; i < 2000; i++) push(8'(i));
    push(8'h00);
    push(8'h01);
    push(8'h5A);
    expq.push_back({1'b1, 1'b1, 8'h5A});
    wait_done(6000, 1'b0);
    check_cap("drop");
    chk("drop_pulses", pulses, 1);
    chk("drop_drop_cnt", drop_cnt, 1);
    chk("drop_frame_cnt", frame_cnt, 3);

    // Zero-length header
    clear_caps();
    push(8'h00);
    push(8'h00);
    tick(5);
    chk("zero_busy", busy, 0);
    chk("zero_rdreq", rdreq, 0);
    chk("zero_drop_cnt", drop_cnt, 2);
    chk("zero_pulses", pulses, 1);
    chk("zero_out", cap.size(), 0);

    // FIFO underrun mid-frame: only 3 of 8 payload bytes present
    clear_caps();
    push(8'h00);
    push(8'h08);
    for (int i = 0; i < 3; i++) push(8'hB0 + 8'(i));
    tick(30);
`ifdef FMAC_RD_STORE_FWD_EN
    chk("part_count", cap.size(), 0);
`else
    chk("part_count", cap.size(), 3);
`endif
    chk("part_busy", busy, 1);
    chk("part_valid", out_valid, 0);
    for (int i = 3; i < 8; i++) push(8'hB0 + 8'(i));
    add_exp(8, 8'hB0);
    wait_done(200, 1'b0);
    check_cap("part");
    chk("part_frame_cnt", frame_cnt, 4);

    // Reset in the middle of a stalled payload
    clear_caps();
    out_ready = 1'b0;
    push_frame(16, 8'h10);
    tick(20);
    chk("mid_busy", busy, 1);
    chk("mid_valid", out_valid, 1);
    chk("mid_data", {out_sop, out_eop, out_data}, {1'b1, 1'b0, 8'h10});
    reset = 1'b1;
    tick(1);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_sop", out_sop, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rdreq", rdreq, 0);
    chk("mid_rst_frame_cnt", frame_cnt, 0);
    chk("mid_rst_drop_cnt", drop_cnt, 0);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    reset = 1'b0;
    out_ready = 1'b1;
    tick(2);

    // Recovery frame after reset
    clear_caps();
    push_frame(2, 8'hC1);
    add_exp(2, 8'hC1);
    wait_done(200, 1'b0);
    check_cap("recover");
    chk("recover_frame_cnt", frame_cnt, 1);
    chk("recover_drop_cnt", drop_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
